// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
//  Module : cpu_ctrl_pkg
//  Brief  : Opcodes, state encoding and control-field encodings for the
//           multi-cycle RV-subset control path.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;

    localparam logic [2:0] c_f3_beq = 3'b000;
    localparam logic [2:0] c_f3_bne = 3'b001;

    localparam logic [1:0] c_imm_i    = 2'b00;
    localparam logic [1:0] c_imm_s    = 2'b01;
    localparam logic [1:0] c_imm_b    = 2'b10;
    localparam logic [1:0] c_imm_none = 2'b11;

    localparam logic [1:0] c_alu_add   = 2'b00;
    localparam logic [1:0] c_alu_sub   = 2'b01;
    localparam logic [1:0] c_alu_funct = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_fsm_opcode_decode.sv
// ============================================================================
//  Module : opcode_decode
//  Brief  : Classifies an opcode/funct3 pair into instruction classes.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module opcode_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    output logic       o_is_load,
    output logic       o_is_store,
    output logic       o_is_branch,
    output logic       o_is_r,
    output logic       o_is_i,
    output logic       o_illegal
);

    assign o_is_load   = (i_opcode == c_op_load);
    assign o_is_store  = (i_opcode == c_op_store);
    // Only BEQ/BNE are implemented; other branch flavours trap.
    assign o_is_branch = (i_opcode == c_op_branch) &&
                         ((i_funct3 == c_f3_beq) || (i_funct3 == c_f3_bne));
    assign o_is_r      = (i_opcode == c_op_r);
    assign o_is_i      = (i_opcode == c_op_i);
    assign o_illegal   = ~(o_is_load | o_is_store | o_is_branch | o_is_r | o_is_i);

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
// ============================================================================
//  Module : multicycle_ctrl_fsm
//  Brief  : FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath strobes.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter bit MEM_WAIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    input  logic             alu_zero,
    output logic [2:0]       state_o,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic [1:0]       imm_sel,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             mem_req,
    output logic             mem_we,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_cnt
);

    state_t           r_state;
    state_t           w_next;
    logic [6:0]       r_opcode;
    logic [2:0]       r_funct3;
    logic [CNT_W-1:0] r_cnt;
    logic             w_retire;
    logic             w_rdy;
    logic [6:0]       w_dec_op;
    logic [2:0]       w_dec_f3;
    logic             w_is_load, w_is_store, w_is_branch, w_is_r, w_is_i, w_dec_illegal;
    logic             w_unused;

    assign w_unused = ^{instr[31:15], instr[11:7]};
    assign w_rdy    = MEM_WAIT ? mem_ready : 1'b1;

    // DECODE classifies the live IR; later states use the latched fields.
    assign w_dec_op = (r_state == S_DECODE) ? instr[6:0]   : r_opcode;
    assign w_dec_f3 = (r_state == S_DECODE) ? instr[14:12] : r_funct3;

    opcode_decode u_dec (
        .i_opcode    (w_dec_op),
        .i_funct3    (w_dec_f3),
        .o_is_load   (w_is_load),
        .o_is_store  (w_is_store),
        .o_is_branch (w_is_branch),
        .o_is_r      (w_is_r),
        .o_is_i      (w_is_i),
        .o_illegal   (w_dec_illegal)
    );

    always_comb begin
        w_next     = r_state;
        w_retire   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        imm_sel    = c_imm_none;
        alu_src_b  = 1'b0;
        alu_op     = c_alu_add;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (w_rdy) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: w_next = w_dec_illegal ? S_TRAP : S_EXEC;
            S_EXEC: begin
                if (w_is_load || w_is_store) begin
                    imm_sel   = w_is_store ? c_imm_s : c_imm_i;
                    alu_src_b = 1'b1;
                    w_next    = S_MEM;
                end else if (w_is_r) begin
                    alu_op = c_alu_funct;
                    w_next = S_WB;
                end else if (w_is_i) begin
                    imm_sel   = c_imm_i;
                    alu_src_b = 1'b1;
                    alu_op    = c_alu_funct;
                    w_next    = S_WB;
                end else if (w_is_branch) begin
                    imm_sel  = c_imm_b;
                    alu_op   = c_alu_sub;
                    pc_src   = 1'b1;
                    pc_write = (r_funct3 == c_f3_bne) ? ~alu_zero : alu_zero;
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else begin
                    w_next = S_TRAP;
                end
            end
            S_MEM: begin
                imm_sel   = w_is_store ? c_imm_s : c_imm_i;
                alu_src_b = 1'b1;
                mem_req   = 1'b1;
                mem_we    = w_is_store;
                if (w_rdy) begin
                    w_retire = w_is_store;
                    w_next   = w_is_store ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = w_is_load;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_TRAP: illegal = 1'b1;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_opcode <= 7'd0;
            r_funct3 <= 3'd0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_opcode <= instr[6:0];
                r_funct3 <= instr[14:12];
            end
            if (w_retire)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign state_o     = r_state;
    assign retired_cnt = r_cnt;

endmodule

`default_nettype wire
